// File: rtl/sram_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_model_pkg
// Description : Shared helpers for the behavioural SRAM macro models:
//               geometry functions and the diagnostic message strings.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_model_pkg;

    // Text used by the elaboration-time geometry check.
    localparam string c_msg_mask_illegal =
        "sram model: DATA_WIDTH must be an integer multiple of WMASK_WIDTH";

    // Text used when an active access carries an unknown address bit.
    localparam string c_msg_addr_unknown =
        "sram model: X/Z address on active access, access dropped";

    // Width of one write-mask segment.
    function automatic int seg_width(input int data_width, input int wmask_width);
        if (wmask_width < 1) begin
            return data_width;
        end
        return data_width / wmask_width;
    endfunction

    // Number of words addressed by an address of the given width.
    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : sram_model_pkg
`default_nettype wire

// File: rtl/sram_wmask_merge.sv
`default_nettype none
// ============================================================================
// Module      : sram_wmask_merge
// Description : Purely combinational write-word builder. Each mask bit
//               selects whether its segment comes from the new data or is
//               kept from the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wmask_merge
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH  = 44,
    parameter int WMASK_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]  old_word,
    input  logic [DATA_WIDTH-1:0]  new_data,
    input  logic [WMASK_WIDTH-1:0] wmask,
    output logic [DATA_WIDTH-1:0]  merged_word
);

    localparam int c_seg = seg_width(DATA_WIDTH, WMASK_WIDTH);

    genvar i;
    for (i = 0; i < WMASK_WIDTH; i++) begin : g_seg
        assign merged_word[i*c_seg +: c_seg] =
            wmask[i] ? new_data[i*c_seg +: c_seg] : old_word[i*c_seg +: c_seg];
    end

endmodule : sram_wmask_merge
`default_nettype wire

// File: rtl/sram_1rw1r_wmask.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_wmask
// Description : Behavioural SRAM macro, one read/write port (0) with
//               per-segment write mask and one read-only port (1).
//               All inputs are registered on clk0; reads and writes act one
//               edge later. Read-during-write on the same address is
//               read-first. Outputs hold their last read value.
//               Optional feature macro: SRAM_COLLISION_CHECK_EN builds the
//               sticky same-address write/read collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw1r_wmask
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH  = 44,
    parameter int ADDR_WIDTH  = 7,
    parameter int WMASK_WIDTH = 4,
    parameter int VERBOSE     = 1
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   collision
);

    localparam int c_depth = ram_depth(ADDR_WIDTH);

    // A mask that does not tile the word evenly is a configuration error.
    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
        $fatal(1, "%s", c_msg_mask_illegal);
    end

    logic [DATA_WIDTH-1:0]  r_mem [c_depth];

    logic                   r_csb0;
    logic                   r_web0;
    logic [WMASK_WIDTH-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0]  r_addr0;
    logic [DATA_WIDTH-1:0]  r_din0;
    logic                   r_csb1;
    logic [ADDR_WIDTH-1:0]  r_addr1;

    logic [DATA_WIDTH-1:0]  r_dout0;
    logic [DATA_WIDTH-1:0]  r_dout1;

    logic                   w_addr0_known;
    logic                   w_addr1_known;
    logic                   w_wr_en;
    logic                   w_rd0_en;
    logic                   w_rd1_en;
    logic [DATA_WIDTH-1:0]  w_old_word;
    logic [DATA_WIDTH-1:0]  w_wr_word;

    // Capture both ports' requests; reset parks both ports deselected so a
    // write captured before reset never commits.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_csb0   <= 1'b1;
            r_web0   <= 1'b1;
            r_wmask0 <= '0;
            r_addr0  <= '0;
            r_din0   <= '0;
            r_csb1   <= 1'b1;
            r_addr1  <= '0;
        end else begin
            r_csb0   <= csb0;
            r_web0   <= web0;
            r_wmask0 <= wmask0;
            r_addr0  <= addr0;
            r_din0   <= din0;
            r_csb1   <= csb1;
            r_addr1  <= addr1;
        end
    end

    // An unknown address bit drops the whole access rather than corrupting
    // an arbitrary word.
    assign w_addr0_known = !$isunknown(r_addr0);
    assign w_addr1_known = !$isunknown(r_addr1);

    assign w_wr_en  = !r_csb0 && !r_web0 && w_addr0_known;
    assign w_rd0_en = !r_csb0 &&  r_web0 && w_addr0_known;
    assign w_rd1_en = !r_csb1 && w_addr1_known;

    assign w_old_word = r_mem[r_addr0];

    sram_wmask_merge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WMASK_WIDTH (WMASK_WIDTH)
    ) u_merge (
        .old_word    (w_old_word),
        .new_data    (r_din0),
        .wmask       (r_wmask0),
        .merged_word (w_wr_word)
    );

    // Commit the merged write word; the array keeps its contents over reset.
    always_ff @(posedge clk0) begin
        if (w_wr_en) begin
            r_mem[r_addr0] <= w_wr_word;
        end
    end

    // Read both ports from the pre-write array contents (read-first);
    // an idle port holds its last value.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_dout0 <= '0;
            r_dout1 <= '0;
        end else begin
            if (w_rd0_en) begin
                r_dout0 <= r_mem[r_addr0];
            end
            if (w_rd1_en) begin
                r_dout1 <= r_mem[r_addr1];
            end
        end
    end

    assign dout0 = r_dout0;
    assign dout1 = r_dout1;

`ifdef SRAM_COLLISION_CHECK_EN
    logic w_collide;
    logic r_collision;

    // A masked-off write changes nothing, so it cannot collide.
    assign w_collide = w_wr_en && (|r_wmask0) && w_rd1_en && (r_addr0 == r_addr1);

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_collision <= 1'b0;
        end else if (w_collide) begin
            r_collision <= 1'b1;
        end
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

    // Transaction trace and address-sanity reporting for simulation logs.
    always @(posedge clk0) begin
        if (!rst0) begin
            if (!r_csb0 && !w_addr0_known) begin
                $warning("%s (%m port 0 addr=%h)", c_msg_addr_unknown, r_addr0);
            end
            if (!r_csb1 && !w_addr1_known) begin
                $warning("%s (%m port 1 addr=%h)", c_msg_addr_unknown, r_addr1);
            end
            if (VERBOSE != 0) begin
                if (w_wr_en) begin
                    $info("%m write addr=%0h din=%h wmask=%b", r_addr0, r_din0, r_wmask0);
                end
                if (w_rd0_en) begin
                    $info("%m read0 addr=%0h data=%h", r_addr0, r_mem[r_addr0]);
                end
                if (w_rd1_en) begin
                    $info("%m read1 addr=%0h data=%h", r_addr1, r_mem[r_addr1]);
                end
            end
`ifdef SRAM_COLLISION_CHECK_EN
            if (w_collide) begin
                $info("COLLISION %m addr=%0h", r_addr0);
            end
`endif
        end
    end

endmodule : sram_1rw1r_wmask
`default_nettype wire

// File: tb/tb_sram_1rw1r_wmask.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_1rw1r_wmask
// Description : Self-checking bench for sram_1rw1r_wmask (32x16, 4 segments).
//               Directed scenarios followed by randomized traffic, checked
//               against a transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_wmask;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int MW  = 4;
    localparam int SEG = DW / MW;
    localparam int DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          csb0;
    logic          web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          collision;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word array plus expected outputs.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_dout0;
    logic [DW-1:0] exp_dout1;
    logic          exp_coll;

    // Request accepted at the last edge, acted upon at the next one.
    logic          p_csb0, p_web0, p_csb1;
    logic [MW-1:0] p_wmask0;
    logic [AW-1:0] p_addr0, p_addr1;
    logic [DW-1:0] p_din0;

    sram_1rw1r_wmask #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WMASK_WIDTH (MW),
        .VERBOSE     (0)
    ) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1),
        .collision (collision)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_dout0 = '0;
        exp_dout1 = '0;
        exp_coll  = 1'b0;
        p_csb0 = 1'b1; p_web0 = 1'b1; p_csb1 = 1'b1;
        p_wmask0 = '0; p_addr0 = '0; p_addr1 = '0; p_din0 = '0;
    endtask

    // One clock edge: advance the model, then compare all outputs.
    task automatic step();
        logic wr;
        @(posedge clk0);
        if (rst0) begin
            model_reset();
        end else begin
            wr = !p_csb0 && !p_web0;
            // Reads see the array as it was before this edge's write.
            if (!p_csb1) exp_dout1 = ref_mem[p_addr1];
            if (!p_csb0 && p_web0) exp_dout0 = ref_mem[p_addr0];
`ifdef SRAM_COLLISION_CHECK_EN
            if (wr && (p_wmask0 != '0) && !p_csb1 && (p_addr0 == p_addr1)) exp_coll = 1'b1;
`endif
            if (wr) begin
                for (int s = 0; s < MW; s++) begin
                    if (p_wmask0[s]) ref_mem[p_addr0][s*SEG +: SEG] = p_din0[s*SEG +: SEG];
                end
            end
            p_csb0 = csb0; p_web0 = web0; p_wmask0 = wmask0;
            p_addr0 = addr0; p_din0 = din0; p_csb1 = csb1; p_addr1 = addr1;
        end
        #1;
        check("dout0", dout0, exp_dout0);
        check("dout1", dout1, exp_dout1);
        check("collision", collision, exp_coll);
    endtask

    task automatic drive(input logic c0, input logic w0, input logic [MW-1:0] m0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic c1, input logic [AW-1:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
        csb1 = c1; addr1 = a1;
        step();
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    endtask

    logic [DW-1:0] init_word;
    logic          exp_rdw_coll;

    initial begin
        rst0 = 1'b0;
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;
        model_reset();

        // Reset takes effect without a clock edge.
        #2 rst0 = 1'b1;
        #1;
        check("rst_dout0", dout0, 32'h0);
        check("rst_dout1", dout1, 32'h0);
        check("rst_coll", collision, 1'b0);
        step();
        step();
        rst0 = 1'b0;

        // Preload every word so the model and the array agree.
        for (int a = 0; a < DEPTH; a++) begin
            case (a)
                2:       init_word = 32'hCAFEF00D;
                5:       init_word = 32'h11223344;
                7:       init_word = 32'h00000000;
                9:       init_word = 32'h0BADC0DE;
                default: init_word = $urandom;
            endcase
            ref_mem[a] = 'x;
            drive(1'b0, 1'b0, 4'hF, AW'(a), init_word, 1'b1, '0);
        end
        idle();

        // Full-word write, then read on both ports.
        drive(1'b0, 1'b0, 4'hF, 4'd3, 32'hDEADBEEF, 1'b1, '0);
        drive(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'd3);
        idle();
        check("full_rd0", dout0, 32'hDEADBEEF);
        check("full_rd1", dout1, 32'hDEADBEEF);

        // Partial mask, then an all-clear mask that must not change the word.
        drive(1'b0, 1'b0, 4'h5, 4'd5, 32'hAABBCCDD, 1'b1, '0);
        drive(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, '0);
        idle();
        check("partial_rd", dout0, 32'h11BB33DD);
        drive(1'b0, 1'b0, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b1, '0);
        drive(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b1, '0);
        idle();
        check("nomask_rd", dout0, 32'h11BB33DD);

        // Same-address write and port 1 read in one cycle: read-first.
`ifdef SRAM_COLLISION_CHECK_EN
        exp_rdw_coll = 1'b1;
`else
        exp_rdw_coll = 1'b0;
`endif
        drive(1'b0, 1'b0, 4'hF, 4'd7, 32'h12345678, 1'b0, 4'd7);
        idle();
        check("rdw_old", dout1, 32'h00000000);
        check("rdw_coll", collision, exp_rdw_coll);
        drive(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd7);
        idle();
        check("rdw_new", dout1, 32'h12345678);

        // Outputs hold through idle cycles.
        drive(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'd2);
        idle();
        for (int k = 0; k < 3; k++) begin
            idle();
            check("hold0", dout0, 32'hCAFEF00D);
            check("hold1", dout1, 32'hCAFEF00D);
        end

        // Reset between a write being captured and being committed.
        drive(1'b0, 1'b0, 4'hF, 4'd9, 32'hFFFFFFFF, 1'b1, '0);
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0;
        rst0 = 1'b1;
        #1;
        model_reset();
        check("midrst_dout0", dout0, 32'h0);
        check("midrst_dout1", dout1, 32'h0);
        check("midrst_coll", collision, 1'b0);
        step();
        step();
        rst0 = 1'b0;
        drive(1'b0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'd2);
        idle();
        check("discard_wr", dout0, 32'h0BADC0DE);
        check("kept_word", dout1, 32'hCAFEF00D);

        // Randomized traffic, addresses biased low to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  MW'($urandom),
                  ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'($urandom_range(0, 2)),
                  DW'($urandom),
                  1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'($urandom_range(0, 2)));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sram_1rw1r_wmask
`default_nettype wire
